multi_tick_gen: RTL and testbench

MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

---
 rtl/multi_tick_gen.sv | 108 ++++++++++
 tb/tb_multi_tick_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: per-channel divisor,
// phase counter, one-cycle tick pulse, optional square wave and tick total.
//
// Ports:
//   clock, reset     : rising-edge clock, async active-high reset
//   enable           : global run enable (low freezes all channels)
//   clear_all        : synchronous restart of every phase counter
//   div_we/div_sel/div_data : divisor write strobe, channel index, value
//   mode[CHANNELS]   : per-channel square-wave toggle enable
//   tick[CHANNELS]   : registered one-cycle pulse per channel
//   square[CHANNELS] : registered square wave, period 2(D+1)
//   tick_count       : flattened per-channel tick totals (wrap silently)
//   phase_out        : phase of channel div_sel, 0 when out of range
module multi_tick_gen #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int DIV_DEFAULT = 2000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear_all,
  input  logic                          div_we,
  input  logic [3:0]                    div_sel,
  input  logic [DIV_WIDTH-1:0]          div_data,
  input  logic [CHANNELS-1:0]           mode,
  output logic [CHANNELS-1:0]           tick,
  output logic [CHANNELS-1:0]           square,
  output logic [CHANNELS*CNT_WIDTH-1:0] tick_count,
  output logic [DIV_WIDTH-1:0]          phase_out
);

  logic [CHANNELS-1:0][DIV_WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0][DIV_WIDTH-1:0] ph_q, ph_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]                tick_q, tick_d;
  logic [CHANNELS-1:0]                sq_q, sq_d;
  logic [CHANNELS-1:0]                wr;

  // Out-of-range div_sel matches no channel, so the write is dropped.
  always_comb begin
    wr = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wr[n] = div_we && (div_sel == 4'(n));
    end
  end

  always_comb begin
    div_d  = div_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    tick_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (wr[n]) begin
        div_d[n] = div_data;
      end
      // Write and clear both restart the phase and beat terminal count.
      if (clear_all || wr[n]) begin
        ph_d[n] = '0;
      end else if (enable) begin
        if (ph_q[n] == div_q[n]) begin
          ph_d[n]   = '0;
          tick_d[n] = 1'b1;
          cnt_d[n]  = cnt_q[n] + CNT_WIDTH'(1);
          if (mode[n]) begin
            sq_d[n] = ~sq_q[n];
          end
        end else begin
          ph_d[n] = ph_q[n] + DIV_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        div_q[n] <= DIV_WIDTH'(DIV_DEFAULT);
      end
      ph_q   <= '0;
      cnt_q  <= '0;
      sq_q   <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    phase_out = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (div_sel == 4'(n)) begin
        phase_out = ph_q[n];
      end
    end
  end

  assign tick       = tick_q;
  assign square     = sq_q;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed self-checking bench for multi_tick_gen.
// Four channels, 4-bit tick counters, default divisor 5.
module tb_multi_tick_gen;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int DD = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           clear_all = 1'b0;
  logic           div_we = 1'b0;
  logic [3:0]     div_sel = '0;
  logic [DW-1:0]  div_data = '0;
  logic [CH-1:0]  mode = '0;
  logic [CH-1:0]  tick;
  logic [CH-1:0]  square;
  logic [CH*CW-1:0] tick_count;
  logic [DW-1:0]  phase_out;

  int checks = 0;
  int failures = 0;

  multi_tick_gen #(
    .CHANNELS(CH), .DIV_WIDTH(DW),
    .CNT_WIDTH(CW), .DIV_DEFAULT(DD)
  ) dut (
    .clock(clk), .reset(rst), .enable(enable),
    .clear_all(clear_all), .div_we(div_we),
    .div_sel(div_sel), .div_data(div_data),
    .mode(mode), .tick(tick), .square(square),
    .tick_count(tick_count), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt(input int n);
    return tick_count[n*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 0; clear_all = 0; div_we = 0;
    div_sel = 0; div_data = 0; mode = 0;
    step();
    rst = 1; #2; rst = 0;
  endtask

  task automatic write_div(input int ch, input int d);
    div_sel = 4'(ch); div_data = DW'(d); div_we = 1;
    step();
    div_we = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (tick !== '0 || square !== '0 || tick_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b %b %h want 0", tick, square, tick_count);
    end
    checks++;
    if (phase_out !== '0) begin
      failures++;
      $display("FAIL reset_phase got %0d want 0", phase_out);
    end
    #5; rst = 0;
  endtask

  task automatic test_default_div();
    int bad = 0;
    apply_reset();
    enable = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (tick[0] !== (i == 6)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL default_div got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_div3();
    int bad = 0;
    apply_reset();
    write_div(0, 3);
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick[0] !== (i % 4 == 3)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL div3_pattern got %0d bad cycles want 0", bad);
    end
    checks++;
    if (cnt(0) !== 4'd5) begin
      failures++;
      $display("FAIL div3_count got %0d want 5", cnt(0));
    end
  endtask

  task automatic test_d0_square();
    int bad = 0;
    apply_reset();
    write_div(1, 0);
    mode = 4'b0010;
    enable = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tick[1] !== 1'b1) bad++;
      if (square[1] !== (i % 2 == 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL d0_square got %0d bad samples want 0", bad);
    end
    checks++;
    if (square[0] !== 1'b0 || tick_count[0*CW +: CW] !== 4'd1) begin
      failures++;
      $display("FAIL mode0_hold got sq=%b cnt=%0d want sq=0 cnt=1", square[0], cnt(0));
    end
  endtask

  task automatic test_enable_gap();
    int bad = 0;
    apply_reset();
    write_div(2, 4);
    enable = 1;
    step(); step();
    checks++;
    if (phase_out !== 16'd2) begin
      failures++;
      $display("FAIL gap_start_phase got %0d want 2", phase_out);
    end
    enable = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (tick[2] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || phase_out !== 16'd2) begin
      failures++;
      $display("FAIL gap_hold got bad=%0d ph=%0d want bad=0 ph=2", bad, phase_out);
    end
    enable = 1;
    step();
    bad = (tick[2] !== 1'b0) ? 1 : 0;
    step();
    if (tick[2] !== 1'b0) bad++;
    step();
    if (tick[2] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL gap_resume got %0d bad cycles want 0", bad);
    end
    enable = 0;
    step();
    checks++;
    if (tick[2] !== 1'b0 || cnt(2) !== 4'd1) begin
      failures++;
      $display("FAIL gap_drop got tick=%b cnt=%0d want tick=0 cnt=1", tick[2], cnt(2));
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    write_div(3, 0);
    enable = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 15) begin
        checks++;
        if (cnt(3) !== 4'd15) begin
          failures++;
          $display("FAIL wrap_15 got %0d want 15", cnt(3));
        end
      end
      if (i == 16) begin
        checks++;
        if (cnt(3) !== 4'd0) begin
          failures++;
          $display("FAIL wrap_16 got %0d want 0", cnt(3));
        end
      end
    end
    checks++;
    if (cnt(3) !== 4'd1) begin
      failures++;
      $display("FAIL wrap_17 got %0d want 1", cnt(3));
    end
  endtask

  task automatic test_rewrite();
    int bad = 0;
    apply_reset();
    mode = 4'b0001;
    write_div(0, 3);
    enable = 1;
    step(); step(); step();
    checks++;
    if (phase_out !== 16'd3) begin
      failures++;
      $display("FAIL rewrite_pre got %0d want 3", phase_out);
    end
    write_div(0, 9);
    checks++;
    if (tick[0] !== 1'b0 || cnt(0) !== 4'd0 ||
        phase_out !== 16'd0 || square[0] !== 1'b0) begin
      failures++;
      $display("FAIL rewrite_collide got t=%b c=%0d p=%0d s=%b want 0 0 0 0",
               tick[0], cnt(0), phase_out, square[0]);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick[0] !== (i == 10)) bad++;
    end
    checks++;
    if (bad != 0 || cnt(0) !== 4'd1 || square[0] !== 1'b1) begin
      failures++;
      $display("FAIL rewrite_next got bad=%0d c=%0d s=%b want 0 1 1",
               bad, cnt(0), square[0]);
    end
    div_sel = 4'd7;
    #1;
    checks++;
    if (phase_out !== 16'd0) begin
      failures++;
      $display("FAIL sel7_phase got %0d want 0", phase_out);
    end
    write_div(7, 1);
    div_sel = 0;
    #1;
    checks++;
    if (phase_out !== 16'd1) begin
      failures++;
      $display("FAIL sel7_ignored got %0d want 1", phase_out);
    end
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (tick[0] !== 1'b1 || cnt(0) !== 4'd2) begin
      failures++;
      $display("FAIL sel7_div_kept got t=%b c=%0d want 1 2", tick[0], cnt(0));
    end
  endtask

  task automatic test_independence();
    apply_reset();
    enable = 1;
    step(); step();
    write_div(0, 7);
    div_sel = 1;
    #1;
    checks++;
    if (phase_out !== 16'd3) begin
      failures++;
      $display("FAIL indep_other got %0d want 3", phase_out);
    end
    div_sel = 0;
    #1;
    checks++;
    if (phase_out !== 16'd0) begin
      failures++;
      $display("FAIL indep_written got %0d want 0", phase_out);
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    apply_reset();
    enable = 1;
    step(); step(); step();
    clear_all = 1;
    write_div(1, 2);
    clear_all = 0;
    #1;
    checks++;
    if (phase_out !== 16'd0) begin
      failures++;
      $display("FAIL clear_wr_ph1 got %0d want 0", phase_out);
    end
    div_sel = 0;
    #1;
    checks++;
    if (phase_out !== 16'd0) begin
      failures++;
      $display("FAIL clear_ph0 got %0d want 0", phase_out);
    end
    div_sel = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (tick[1] !== (i == 3)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_newdiv got %0d bad cycles want 0", bad);
    end
    step(); step();
    clear_all = 1;
    step();
    clear_all = 0;
    checks++;
    if (tick !== '0 || cnt(1) !== 4'd1 || cnt(0) !== 4'd0 ||
        phase_out !== 16'd0) begin
      failures++;
      $display("FAIL clear_terminal got t=%b c1=%0d c0=%0d p=%0d want 0 1 0 0",
               tick, cnt(1), cnt(0), phase_out);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    apply_reset();
    mode = 4'b1111;
    write_div(0, 1);
    enable = 1;
    step(); step(); step();
    checks++;
    if (cnt(0) !== 4'd1 || square[0] !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got c=%0d s=%b want 1 1", cnt(0), square[0]);
    end
    #3;
    rst = 1;
    #1;
    checks++;
    if (tick !== '0 || square !== '0 || tick_count !== '0 ||
        phase_out !== '0) begin
      failures++;
      $display("FAIL areset_now got t=%b s=%b c=%h p=%0d want all 0",
               tick, square, tick_count, phase_out);
    end
    #2;
    rst = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (tick[0] !== (i == 6)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL areset_default got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div3();
    test_d0_square();
    test_enable_gap();
    test_wrap();
    test_rewrite();
    test_independence();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
